// File: rtl/hamming_secded_codec_if.sv
// Stream interface for the SECDED codec: input word channel and result channel.
// Codeword widths are derived from DATA_W so that master and slave agree on sizing.
interface hamming_secded_codec_if #(
  parameter int DATA_W = 7
);
  function automatic int par_bits(input int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  localparam int PAR_W = par_bits(DATA_W);
  localparam int CW_W  = DATA_W + PAR_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [CW_W-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_mode;
  logic [CW_W-1:0]   out_data;
  logic [1:0]        out_err;
  logic [PAR_W-1:0]  out_syndrome;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data, out_err, out_syndrome
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data, out_err, out_syndrome
  );
endinterface

// File: rtl/hamming_secded_codec.sv
// Extended-Hamming SECDED encoder/decoder behind a 2-stage valid/ready pipeline,
// with saturating counters of corrected and uncorrectable delivered words.
module hamming_secded_codec #(
  parameter int DATA_W = 7,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hamming_secded_codec_if.slave bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     cnt_corr,
  output logic [CNT_W-1:0]     cnt_uncorr
);
  function automatic int par_bits(input int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  localparam int PAR_W = par_bits(DATA_W);
  localparam int N     = DATA_W + PAR_W;
  localparam int CW_W  = N + 1;

  logic              s1_v_q, s1_mode_q;
  logic [CW_W-1:0]   s1_data_q;
  logic              s2_v_q, out_mode_q;
  logic [CW_W-1:0]   out_data_q, res_data_d;
  logic [1:0]        out_err_q, res_err_d;
  logic [PAR_W-1:0]  out_syn_q, res_syn_d;
  logic [CNT_W-1:0]  cnt_corr_q, cnt_uncorr_q;

  logic              s2_adv, in_rdy, out_hs;
  logic [CW_W-1:0]   enc_cw, dec_cw;
  logic [PAR_W-1:0]  enc_syn, dec_syn;
  logic [DATA_W-1:0] dec_dat;
  logic [1:0]        dec_err;
  logic              dec_pmis;
  int unsigned       ej, dj;

  assign s2_adv = !s2_v_q || bus.out_ready;
  assign in_rdy = !s1_v_q || s2_adv;
  assign out_hs = s2_v_q && bus.out_ready;

  // Parity bit k equals bit k of the XOR of positions holding a set data bit.
  always_comb begin
    enc_cw  = '0;
    enc_syn = '0;
    ej      = 0;
    for (int unsigned pos = 1; pos <= N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        enc_cw[pos] = s1_data_q[ej];
        if (s1_data_q[ej]) enc_syn = enc_syn ^ pos[PAR_W-1:0];
        ej = ej + 1;
      end
    end
    for (int unsigned k = 0; k < PAR_W; k++) enc_cw[1 << k] = enc_syn[k];
    enc_cw[0] = ^enc_cw[CW_W-1:1];
  end

  always_comb begin
    dec_syn  = '0;
    for (int unsigned pos = 1; pos <= N; pos++)
      if (s1_data_q[pos]) dec_syn = dec_syn ^ pos[PAR_W-1:0];
    dec_pmis = ^s1_data_q;
    dec_cw   = s1_data_q;
    dec_err  = 2'b00;
    if (dec_syn == '0) begin
      if (dec_pmis) dec_err = 2'b01;
    end else if (dec_pmis && int'(dec_syn) <= N) begin
      dec_cw[dec_syn] = ~dec_cw[dec_syn];
      dec_err         = 2'b01;
    end else begin
      dec_err = 2'b10;
    end
    dec_dat = '0;
    dj      = 0;
    for (int unsigned pos = 1; pos <= N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        dec_dat[dj] = dec_cw[pos];
        dj = dj + 1;
      end
    end
  end

  always_comb begin
    res_data_d = s1_mode_q ? CW_W'(dec_dat) : enc_cw;
    res_err_d  = s1_mode_q ? dec_err : 2'b00;
    res_syn_d  = s1_mode_q ? dec_syn : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_data_q  <= '0;
      s2_v_q     <= 1'b0;
      out_mode_q <= 1'b0;
      out_data_q <= '0;
      out_err_q  <= '0;
      out_syn_q  <= '0;
    end else begin
      if (in_rdy) s1_v_q <= bus.in_valid;
      if (in_rdy && bus.in_valid) begin
        s1_mode_q <= bus.in_mode;
        s1_data_q <= bus.in_data;
      end
      if (s2_adv) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          out_mode_q <= s1_mode_q;
          out_data_q <= res_data_d;
          out_err_q  <= res_err_d;
          out_syn_q  <= res_syn_d;
        end
      end
    end
  end

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else if (cnt_clr) begin
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else if (out_hs) begin
      if (out_err_q == 2'b01 && cnt_corr_q != '1)   cnt_corr_q   <= cnt_corr_q + 1'b1;
      if (out_err_q == 2'b10 && cnt_uncorr_q != '1) cnt_uncorr_q <= cnt_uncorr_q + 1'b1;
    end
  end

  assign bus.in_ready     = in_rdy;
  assign bus.out_valid    = s2_v_q;
  assign bus.out_mode     = out_mode_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_err      = out_err_q;
  assign bus.out_syndrome = out_syn_q;
  assign cnt_corr         = cnt_corr_q;
  assign cnt_uncorr       = cnt_uncorr_q;
endmodule
